// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and sizing helpers for the bit-serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // Bit-counter width: enough to index WIDTH-1, never less than one bit
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: one-bit full adder reused by the serial adder on every RUN cycle
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder, one full-adder step per RUN cycle.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
import serial_add_pkg::*;

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state, next_state;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [WIDTH-2:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             accept, last;

    assign accept    = (state == IDLE) && start;
    assign last      = (state == RUN) && (cnt == CW'(WIDTH - 1));
    // The sum bit of this step lands in the MSB; the oldest bit falls out at [0]
    assign psum_next = {fa_s, psum};

    fa_cell u_fa (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state: IDLE waits for start, RUN lasts WIDTH cycles, DONE lasts one
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? RUN : IDLE;
            RUN:     next_state = last ? DONE : RUN;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Operand shift registers, carry, partial sum and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            psum  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            psum  <= psum_next[WIDTH-1:1];
            carry <= fa_co;
            cnt   <= last ? cnt : cnt + 1'b1;
        end
    end

    // Result registers load only on the final RUN step so partial sums never show
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last) begin
            sum  <= psum_next;
            cout <= fa_co;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the last step the carry register holds the carry into the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ovf <= 1'b0;
        else if (last) ovf <= carry ^ fa_co;
    end
`endif

endmodule
